// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker for a convolutional encoder / Viterbi decoder pair.
// Source bits going into the encoder are queued in a small bit FIFO. Decoded
// bits coming out of the decoder are compared, in order, against that queue.
// The first SKIP decoded bits are traceback flush and are thrown away.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-low reset
//   ref_valid_i   qualifies ref_bit_i (encoder input enable)
//   ref_bit_i     uncoded source bit
//   dec_valid_i   qualifies dec_bit_i (decoder output strobe)
//   dec_bit_i     decoded bit
//   clear_i       synchronous soft reset, same effect as rst low
//   bit_count_o   number of compared bits (saturating)
//   err_count_o   number of mismatched bits (saturating)
//   burst_max_o   longest run of consecutive mismatches (saturating)
//   fifo_level_o  current reference FIFO occupancy
//   overflow_o    sticky: push attempted while the FIFO was full
//   underflow_o   sticky: compare attempted while the FIFO was empty
//   state_o       IDLE=0, SKIP=1, COMPARE=2, FAULT=3
module viterbi_ber_checker #(
    parameter int DEPTH = 64,
    parameter int SKIP  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ref_valid_i,
    input  logic                     ref_bit_i,
    input  logic                     dec_valid_i,
    input  logic                     dec_bit_i,
    input  logic                     clear_i,
    output logic [31:0]              bit_count_o,
    output logic [31:0]              err_count_o,
    output logic [15:0]              burst_max_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    output logic [1:0]               state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_COMPARE = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    state_t        state, state_nxt;
    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [7:0]    skip_cnt;
    logic [15:0]   run_len;
    logic [31:0]   bit_count, err_count;
    logic [15:0]   burst_max;
    logic          overflow, underflow;

    logic          full, empty;
    logic          do_push, do_pop, do_cmp, bypass, cmp_ref;
    logic          set_ovf, set_udf, skip_inc, mismatch, soft_rst;
    logic [15:0]   run_inc;

    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign soft_rst = !rst || clear_i;
    assign mismatch = do_cmp && (cmp_ref != dec_bit_i);
    assign run_inc  = sat_inc16(run_len);

    always_comb begin
        state_nxt = state;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_cmp    = 1'b0;
        bypass    = 1'b0;
        cmp_ref   = mem[rd_ptr];
        set_ovf   = 1'b0;
        set_udf   = 1'b0;
        skip_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ref_valid_i)
                    state_nxt = (SKIP == 0) ? ST_COMPARE : ST_SKIP;
            end
            ST_SKIP: begin
                if (dec_valid_i) begin
                    skip_inc = 1'b1;
                    if (int'(skip_cnt) + 1 == SKIP)
                        state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (dec_valid_i) begin
                    if (!empty) begin
                        do_pop = 1'b1;
                        do_cmp = 1'b1;
                    end else if (ref_valid_i) begin
                        // Empty queue with a bit arriving: compare straight
                        // against the incoming bit; push and pop cancel out.
                        bypass  = 1'b1;
                        do_cmp  = 1'b1;
                        cmp_ref = ref_bit_i;
                    end else begin
                        set_udf   = 1'b1;
                        state_nxt = ST_FAULT;
                    end
                end
            end
            default: ;
        endcase
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (state != ST_FAULT && ref_valid_i && !bypass) begin
            if (full && !do_pop) begin
                set_ovf   = 1'b1;
                state_nxt = ST_FAULT;
            end else begin
                do_push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            skip_cnt  <= '0;
            run_len   <= '0;
            bit_count <= '0;
            err_count <= '0;
            burst_max <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (skip_inc) skip_cnt <= skip_cnt + 8'd1;
            if (do_cmp) begin
                bit_count <= sat_inc32(bit_count);
                if (mismatch) begin
                    err_count <= sat_inc32(err_count);
                    run_len   <= run_inc;
                    if (run_inc > burst_max) burst_max <= run_inc;
                end else begin
                    run_len <= '0;
                end
            end
            if (set_ovf) overflow  <= 1'b1;
            if (set_udf) underflow <= 1'b1;
        end
    end

    // Storage only; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (do_push && !soft_rst) mem[wr_ptr] <= ref_bit_i;
    end

    assign bit_count_o  = bit_count;
    assign err_count_o  = err_count;
    assign burst_max_o  = burst_max;
    assign fifo_level_o = level;
    assign overflow_o   = overflow;
    assign underflow_o  = underflow;
    assign state_o      = state;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
module tb_viterbi_ber_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ref_valid, ref_bit, dec_valid, dec_bit, clr;

    logic [31:0] bc0, ec0, bc4, ec4;
    logic [15:0] bm0, bm4;
    logic [6:0]  lvl0, lvl4;
    logic        ovf0, udf0, ovf4, udf4;
    logic [1:0]  st0, st4;

    viterbi_ber_checker #(.DEPTH(64), .SKIP(0)) dut0 (
        .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
        .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clr),
        .bit_count_o(bc0), .err_count_o(ec0), .burst_max_o(bm0),
        .fifo_level_o(lvl0), .overflow_o(ovf0), .underflow_o(udf0), .state_o(st0)
    );

    viterbi_ber_checker #(.DEPTH(64), .SKIP(4)) dut4 (
        .clk(clk), .rst(rst), .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
        .dec_valid_i(dec_valid), .dec_bit_i(dec_bit), .clear_i(clr),
        .bit_count_o(bc4), .err_count_o(ec4), .burst_max_o(bm4),
        .fifo_level_o(lvl4), .overflow_o(ovf4), .underflow_o(udf4), .state_o(st4)
    );

    typedef struct {
        int          stamp;
        int          which;
        int          tag;
        logic [31:0] bc;
        logic [31:0] ec;
        logic [15:0] bm;
        logic [6:0]  lvl;
        logic        ovf;
        logic        udf;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: outputs registered at the edge stamped in the entry are
    // compared on the following falling edge.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [90:0] act, want;
        while (exp_q.size() > 0 && exp_q[0].stamp <= cyc_n) begin
            e = exp_q.pop_front();
            if (e.which == 0) act = {bc0, ec0, bm0, lvl0, ovf0, udf0, st0};
            else              act = {bc4, ec4, bm4, lvl4, ovf4, udf4, st4};
            want = {e.bc, e.ec, e.bm, e.lvl, e.ovf, e.udf, e.st};
            n_tests++;
            if (act !== want) begin
                n_fail++;
                $display("FAIL tag%0d dut_skip%0d cyc%0d got bc=%0d ec=%0d bm=%0d lvl=%0d ovf=%0b udf=%0b st=%0d want bc=%0d ec=%0d bm=%0d lvl=%0d ovf=%0b udf=%0b st=%0d",
                         e.tag, (e.which == 0) ? 0 : 4, cyc_n,
                         act[90:59], act[58:27], act[26:11], act[10:4], act[3], act[2], act[1:0],
                         e.bc, e.ec, e.bm, e.lvl, e.ovf, e.udf, e.st);
            end
        end
    end

    function automatic logic pat(input int k);
        int t;
        t = k ^ (k >> 2);
        return t[0];
    endfunction

    task automatic drive(input logic rv, input logic rb, input logic dv,
                         input logic db, input logic cl, input logic rs);
        ref_valid = rv;
        ref_bit   = rb;
        dec_valid = dv;
        dec_bit   = db;
        clr       = cl;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int which, input int tag,
                              input int bc, input int ec, input int bm,
                              input int lvl, input logic ovf, input logic udf,
                              input int st);
        exp_t e;
        e.stamp = cyc_n;
        e.which = which;
        e.tag   = tag;
        e.bc    = 32'(bc);
        e.ec    = 32'(ec);
        e.bm    = 16'(bm);
        e.lvl   = 7'(lvl);
        e.ovf   = ovf;
        e.udf   = udf;
        e.st    = 2'(st);
        exp_q.push_back(e);
    endtask

    task automatic expect_zero(input int tag);
        expect_out(0, tag, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        expect_out(1, tag, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    initial begin
        ref_valid = 0; ref_bit = 0; dec_valid = 0; dec_bit = 0; clr = 0; rst = 0;

        // Reset while inputs are active: reset wins
        drive(1, 1, 1, 1, 0, 0);
        expect_zero(1);

        // SKIP=0: 100 bits returned identically, decoder lagging by 10
        for (int k = 0; k < 110; k++) begin
            int pushes, pops;
            drive(k < 100, pat(k), k >= 10, (k >= 10) ? pat(k - 10) : 1'b0, 0, 1);
            pushes = (k < 100) ? k + 1 : 100;
            pops   = (k >= 10) ? k - 9 : 0;
            expect_out(0, 2, pops, 0, 0, pushes - pops, 1'b0, 1'b0, 2);
        end

        // SKIP=4: 4 junk bits then 50 bits, bits 10..13 inverted
        drive(1, 1, 1, 0, 0, 0);
        expect_zero(3);
        for (int k = 0; k < 56; k++) begin
            int   j, pushes, pops, ecx;
            logic db;
            j = k - 6;
            if (k < 6) db = k[0];
            else       db = pat(j + 3) ^ (j >= 10 && j <= 13);
            drive(k < 50, pat(k + 3), k >= 2, db, 0, 1);
            pushes = (k < 50) ? k + 1 : 50;
            pops   = (k >= 6) ? k - 5 : 0;
            ecx    = (k < 6 || j < 10) ? 0 : ((j - 9 > 4) ? 4 : j - 9);
            expect_out(1, 4, pops, ecx, ecx, pushes - pops, 1'b0, 1'b0, (k <= 4) ? 1 : 2);
        end

        // Overflow: 65 pushes, no pops
        drive(0, 0, 0, 0, 0, 0);
        expect_zero(5);
        for (int k = 0; k < 65; k++) begin
            drive(1, pat(k), 0, 0, 0, 1);
            if (k < 64) expect_out(0, 6, 0, 0, 0, k + 1, 1'b0, 1'b0, 2);
            else begin
                expect_out(0, 6, 0, 0, 0, 64, 1'b1, 1'b0, 3);
                expect_out(1, 6, 0, 0, 0, 64, 1'b1, 1'b0, 3);
            end
        end
        drive(1, 0, 1, 1, 0, 1);
        expect_out(0, 7, 0, 0, 0, 64, 1'b1, 1'b0, 3);
        expect_out(1, 7, 0, 0, 0, 64, 1'b1, 1'b0, 3);

        // Full FIFO push+pop, drain, empty bypass, then underflow
        drive(0, 0, 0, 0, 0, 0);
        expect_zero(8);
        for (int k = 0; k < 64; k++) begin
            drive(1, pat(k), 0, 0, 0, 1);
            expect_out(0, 9, 0, 0, 0, k + 1, 1'b0, 1'b0, 2);
        end
        drive(1, pat(64), 1, pat(0), 0, 1);
        expect_out(0, 10, 1, 0, 0, 64, 1'b0, 1'b0, 2);
        drive(1, pat(65), 1, ~pat(1), 0, 1);
        expect_out(0, 10, 2, 1, 1, 64, 1'b0, 1'b0, 2);
        for (int k = 66; k < 130; k++) begin
            drive(0, 0, 1, pat(k - 64), 0, 1);
            expect_out(0, 11, k - 63, 1, 1, 129 - k, 1'b0, 1'b0, 2);
        end
        drive(1, 1, 1, 0, 0, 1);
        expect_out(0, 12, 67, 2, 1, 0, 1'b0, 1'b0, 2);
        drive(1, 0, 1, 0, 0, 1);
        expect_out(0, 12, 68, 2, 1, 0, 1'b0, 1'b0, 2);
        drive(0, 0, 1, 1, 0, 1);
        expect_out(0, 13, 68, 2, 1, 0, 1'b0, 1'b1, 3);
        drive(1, 1, 1, 1, 0, 1);
        expect_out(0, 13, 68, 2, 1, 0, 1'b0, 1'b1, 3);

        // Clear exits FAULT
        drive(0, 0, 0, 0, 1, 1);
        expect_zero(14);

        // 30 compares, then clear mid-stream with traffic present
        for (int k = 0; k < 35; k++) begin
            int pops;
            drive(1, pat(k + 5), k >= 5, pat(k), 0, 1);
            pops = (k >= 5) ? k - 4 : 0;
            expect_out(0, 15, pops, 0, 0, k + 1 - pops, 1'b0, 1'b0, 2);
        end
        drive(1, pat(40), 1, pat(35), 1, 1);
        expect_zero(16);

        // Clean restart: 20 bits with bit 7 inverted
        for (int k = 0; k < 23; k++) begin
            int pushes, pops, e1;
            drive(k < 20, pat(k + 9), k >= 3, (k >= 3) ? (pat(k + 6) ^ (k == 10)) : 1'b0, 0, 1);
            pushes = (k < 20) ? k + 1 : 20;
            pops   = (k >= 3) ? k - 2 : 0;
            e1     = (k >= 10) ? 1 : 0;
            expect_out(0, 17, pops, e1, e1, pushes - pops, 1'b0, 1'b0, 2);
        end

        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
